// File: rtl/axi_axis_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_axis_reader_pkg
//  Description : Shared constants and types for the AXI4-Lite stream reader.
//                Holds the response codes, register offsets, status bit
//                positions and the read-channel state encoding.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package axi_axis_reader_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register map; only address bit 2 separates the two registers.
  localparam int unsigned DATA_OFFSET   = 0;
  localparam int unsigned STATUS_OFFSET = 4;

  // Status register layout: fill level in the low half-word.
  localparam int unsigned STAT_EMPTY_BIT = 16;
  localparam int unsigned STAT_FULL_BIT  = 17;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } rd_state_t;

endpackage : axi_axis_reader_pkg
`default_nettype wire

// File: rtl/axis_reader_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_reader_fifo
//  Description : Synchronous prefetch FIFO, 2^DEPTH_LOG2 words of WIDTH bits.
//                Head word is presented combinationally on o_rdata. Pushes
//                while full and pops while empty are ignored.
//  Ports       : clk, rst (async, active-high)
//                i_push/i_wdata   write side
//                i_pop/o_rdata    read side (show-ahead)
//                o_full/o_empty/o_count  occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module axis_reader_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam logic [DEPTH_LOG2:0] c_FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_wr;
  logic                  w_rd;

  assign o_full  = (r_count == c_FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_wr = i_push & ~o_full;
  assign w_rd = i_pop & ~o_empty;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at their width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + DEPTH_LOG2'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + DEPTH_LOG2'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : axis_reader_fifo
`default_nettype wire

// File: rtl/axi_axis_reader.sv
`default_nettype none
// ============================================================================
//  Module      : axi_axis_reader
//  Description : AXI4-Lite read-only slave draining an AXI4-Stream through a
//                prefetch FIFO. Each read of the data register pops one word;
//                an empty FIFO answers SLVERR with zero data.
//                Optional macro AXI_AXIS_READER_STATUS_EN adds a status
//                register at offset 4 (count, empty, full). Without it the
//                read address is ignored and every read hits the data register.
//  Ports       : aclk, areset (async, active-high)
//                s_axi_ar*  read address channel
//                s_axi_r*   read data channel (one outstanding read)
//                s_axis_*   stream input, tready = FIFO not full
//  Revision    : 1.0  initial release
// ============================================================================
module axi_axis_reader
  import axi_axis_reader_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter int unsigned AXI_ADDR_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready
);

  rd_state_t                 r_state;
  rd_state_t                 w_state_nxt;
  logic                      r_rst_done;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [AXI_DATA_WIDTH-1:0] w_rdata_nxt;
  logic [1:0]                r_rresp;
  logic [1:0]                w_rresp_nxt;
  logic                      w_ar_hs;
  logic                      w_sel_status;
  logic                      w_pop;
  logic                      w_push;
  logic [AXI_DATA_WIDTH-1:0] w_head;
  logic                      w_full;
  logic                      w_empty;
  logic [FIFO_DEPTH_LOG2:0]  w_count;
  logic                      w_unused;

  // Only address bit 2 matters; the rest of the bus is deliberately dropped.
  assign w_unused = ^{s_axi_araddr, w_count};

  // r_rst_done keeps both ready outputs low while reset is held and for the
  // remainder of the cycle in which it is released.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  assign s_axi_arready = r_rst_done & (r_state == ST_IDLE);
  assign s_axi_rvalid  = (r_state == ST_RESP);
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axis_tready = r_rst_done & ~w_full;

  assign w_ar_hs = s_axi_arvalid & s_axi_arready;
  assign w_push  = s_axis_tvalid & s_axis_tready;

`ifdef AXI_AXIS_READER_STATUS_EN
  logic [AXI_DATA_WIDTH-1:0] w_status;

  assign w_sel_status = s_axi_araddr[2];

  always_comb begin
    w_status                             = '0;
    w_status[FIFO_DEPTH_LOG2:0]          = w_count;
    w_status[STAT_EMPTY_BIT]             = w_empty;
    w_status[STAT_FULL_BIT]              = w_full;
  end
`else
  assign w_sel_status = 1'b0;
`endif

  // Pop only on a data-register handshake with something to hand back.
  assign w_pop = w_ar_hs & ~w_sel_status & ~w_empty;

  axis_reader_fifo #(
    .WIDTH      (AXI_DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .i_push  (w_push),
    .i_wdata (s_axis_tdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else begin
      r_state <= w_state_nxt;
      r_rdata <= w_rdata_nxt;
      r_rresp <= w_rresp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = r_rdata;
    w_rresp_nxt = r_rresp;
    case (r_state)
      ST_IDLE: begin
        if (w_ar_hs) begin
          w_state_nxt = ST_RESP;
`ifdef AXI_AXIS_READER_STATUS_EN
          if (w_sel_status) begin
            w_rdata_nxt = w_status;
            w_rresp_nxt = RESP_OKAY;
          end else
`endif
          if (w_empty) begin
            w_rdata_nxt = '0;
            w_rresp_nxt = RESP_SLVERR;
          end else begin
            w_rdata_nxt = w_head;
            w_rresp_nxt = RESP_OKAY;
          end
        end
      end
      ST_RESP: begin
        if (s_axi_rready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule : axi_axis_reader
`default_nettype wire

// File: doc/axi_axis_reader.md
# axi_axis_reader

AXI4-Lite read-only slave that drains an AXI4-Stream into the processor's address space. It is the read-side counterpart of the stream writer and sits between the PS general-purpose AXI port and PL data producers such as ADC decimators and status pipes. Incoming stream words go into an internal prefetch FIFO. Each AXI read of the data register pops one word. An optional status register reports the FIFO fill level.

## Interface
- AXI_DATA_WIDTH, 32: AXI read data and stream tdata width; must be ≥ 32.
- AXI_ADDR_WIDTH, 16: AXI read address width.
- FIFO_DEPTH_LOG2, 4: prefetch FIFO depth is 2^FIFO_DEPTH_LOG2 words; legal range 1..15.

Ports:
- aclk  in  1  single clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axi_araddr  in  AXI_ADDR_WIDTH  read address; only bit 2 is decoded.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  AXI_DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axis_tdata  in  AXI_DATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready; equals FIFO not full.

## Operation
- The FIFO pushes on s_axis_tvalid & s_axis_tready.
- count (width FIFO_DEPTH_LOG2+1) tracks the number of stored words.
  - Push and pop in the same cycle leave count unchanged.
  - Read and write pointers wrap modulo 2^FIFO_DEPTH_LOG2.
- Read FSM has two states, IDLE and RESP. Only one read is outstanding at a time.
- IDLE: s_axi_arready=1. On arvalid, in that same cycle:
  - Decode araddr[2].
  - Register rdata and rresp.
  - Go to RESP.
- RESP: s_axi_arready=0 and s_axi_rvalid=1. rdata and rresp hold stable until rready, then return to IDLE.
- Data register (araddr[2]=0):
  - FIFO non-empty: pop the head word into rdata, rresp=OKAY. The pop happens in the AR-handshake cycle.
  - FIFO empty: rdata=0, rresp=SLVERR, no pop, pointers untouched.
- Status register (araddr[2]=1, only with the macro defined; see Configuration):
  - rdata[15:0] = count, zero-extended.
  - rdata[16] = empty; rdata[17] = full.
  - All other bits are 0.
  - rresp=OKAY, no pop.
- Reset values:
  - s_axi_arready=0 while areset is high, 1 from the first edge after release.
  - s_axi_rvalid=0, s_axi_rdata=0, s_axi_rresp=0.
  - FIFO empty, count=0.
  - s_axis_tready=0 while areset is high.
- Reset mid-transaction aborts any pending response (rvalid drops immediately, asynchronously) and discards all FIFO contents.

## Timing
- AR handshake at edge N gives rvalid=1 after edge N. Response latency is 1 cycle.
- Back-to-back reads: the next AR handshake can occur in the cycle after the R handshake. Sustained throughput is 1 read per 2 cycles.
- A word pushed at edge N is poppable by an AR handshake at edge N+1 or later. There is no bypass of an empty FIFO.
- When full, s_axis_tready=0. A pop at edge N reasserts tready after edge N.
- Status reads sample count in the AR-handshake cycle, before any same-cycle push takes effect.

## Configuration
- AXI_AXIS_READER_STATUS_EN defined:
  - araddr[2]=1 selects the status register as above.
- AXI_AXIS_READER_STATUS_EN undefined:
  - araddr is ignored entirely; every read targets the data register.
  - No status mux is synthesised.

## Structure
- Shared package axi_axis_reader_pkg holds:
  - RESP_OKAY and RESP_SLVERR constants.
  - Register offsets DATA_OFFSET=0 and STATUS_OFFSET=4.
  - Status bit positions STAT_EMPTY_BIT=16 and STAT_FULL_BIT=17.
  - The two-state FSM enum type.
- One sub-module, axis_reader_fifo: synchronous FIFO, parameterised by width and depth-log2, with push/pop/full/empty/count ports and asynchronous active-high reset.
- The top level contains the FSM, the address decode and the response registers.

## Test plan
- Reset, then read offset 0 with the stream idle -> rvalid after 1 cycle, rdata=0, rresp=2'b10, arready=1 again after rready.
- Push 0x11111111, 0x22222222, 0x33333333, then three data reads with rready tied high -> rdata returns the words in push order, rresp=OKAY, final count=0.
- Default depth 16: push 17 words with tvalid held high -> tready=0 after the 16th push; one read returns word 1; the 17th word is accepted on the next edge.
- Macro defined, push 5 words, read offset 4 -> rdata=0x00000005 (empty=0, full=0). With 16 words stored -> rdata=0x00020010.
- Hold rready=0 for 10 cycles after a data read -> rdata and rvalid stay stable, arready stays 0, and only one word has been popped.
- Assert areset while rvalid=1 with 3 words stored -> rvalid drops immediately; after release a data read returns SLVERR with rdata=0.
